// File: rtl/mchan_ipa_pkg.sv
// Shared types for the transfer completion tracker: SID and outstanding-burst counter widths.
package mchan_ipa_pkg;

   localparam int unsigned PKG_SID_WIDTH = 2;
   localparam int unsigned PKG_CNT_WIDTH = 4;

   typedef logic [PKG_SID_WIDTH-1:0] sid_t;
   typedef logic [PKG_CNT_WIDTH-1:0] cnt_t;

   localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/trans_cnt_slot_ipa.sv
// One SID slot: outstanding-burst counter, last/active flags and registered termination pulse.
module trans_cnt_slot_ipa
   import mchan_ipa_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = PKG_CNT_WIDTH
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       inc_i,
   input  logic [1:0] dec_i,
   input  logic       last_set_i,
   output logic       term_o,
   output logic       full_o,
   output logic       active_o,
   output logic       last_seen_o,
   output logic       underflow_o
);

   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;
   logic                 last_q;
   logic                 active_q;
   logic                 term_q;
   logic [CNT_WIDTH:0]   sum;
   logic [CNT_WIDTH:0]   eff_dec;
   logic                 underflow;
   logic                 last_d;
   logic                 active_d;
   logic                 term_d;

   always_comb begin
      // Completions on an idle slot are flagged at the top and must not touch the count.
      eff_dec   = active_q ? {{(CNT_WIDTH-1){1'b0}}, dec_i} : '0;
      sum       = {1'b0, cnt_q} + {{CNT_WIDTH{1'b0}}, inc_i};
      underflow = (sum < eff_dec);
      cnt_d     = underflow ? '0
                            : cnt_q + {{(CNT_WIDTH-1){1'b0}}, inc_i} - eff_dec[CNT_WIDTH-1:0];
      last_d    = last_q | last_set_i;
      active_d  = active_q | inc_i;
      term_d    = last_d & active_d & (cnt_d == '0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         last_q   <= 1'b0;
         active_q <= 1'b0;
         term_q   <= 1'b0;
      end else if (term_d) begin
         cnt_q    <= '0;
         last_q   <= 1'b0;
         active_q <= 1'b0;
         term_q   <= 1'b1;
      end else begin
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         active_q <= active_d;
         term_q   <= 1'b0;
      end
   end

   assign term_o      = term_q;
   assign full_o      = &cnt_q;
   assign active_o    = active_q;
   assign last_seen_o = last_q;
   assign underflow_o = underflow;

endmodule

// File: rtl/trans_term_tracker_ipa.sv
// Per-transfer completion tracker: counts issued vs. retired bursts per SID and pulses
// term_sig_o once a transfer's last burst is issued and all its bursts have retired.
module trans_term_tracker_ipa
   import mchan_ipa_pkg::*;
#(
   parameter int unsigned NB_TRANSFERS    = 4,
   parameter int unsigned TRANS_SID_WIDTH = PKG_SID_WIDTH,
   parameter int unsigned CNT_WIDTH       = PKG_CNT_WIDTH
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       issue_req_i,
   output logic                       issue_gnt_o,
   input  logic [TRANS_SID_WIDTH-1:0] issue_sid_i,
   input  logic                       issue_last_i,
   input  logic                       tx_cpl_i,
   input  logic [TRANS_SID_WIDTH-1:0] tx_cpl_sid_i,
   input  logic                       rx_cpl_i,
   input  logic [TRANS_SID_WIDTH-1:0] rx_cpl_sid_i,
   output logic [NB_TRANSFERS-1:0]    term_sig_o,
   output logic [NB_TRANSFERS-1:0]    busy_o,
   output logic                       err_o
);

   logic [NB_TRANSFERS-1:0] full_vec;
   logic [NB_TRANSFERS-1:0] active_vec;
   logic [NB_TRANSFERS-1:0] err_vec;
   logic                    issue_fire;
   logic                    err_q;

   // Grant depends only on the addressed slot's registered count, never on completions.
   assign issue_gnt_o = ~full_vec[issue_sid_i];
   assign issue_fire  = issue_req_i & issue_gnt_o;

   generate
      for (genvar gi = 0; gi < NB_TRANSFERS; gi++) begin : g_slot
         logic       inc;
         logic       tx_hit;
         logic       rx_hit;
         logic [1:0] dec;
         logic       last_seen;
         logic       underflow;

         assign inc    = issue_fire & (issue_sid_i == TRANS_SID_WIDTH'(gi));
         assign tx_hit = tx_cpl_i & (tx_cpl_sid_i == TRANS_SID_WIDTH'(gi));
         assign rx_hit = rx_cpl_i & (rx_cpl_sid_i == TRANS_SID_WIDTH'(gi));
         assign dec    = {1'b0, tx_hit} + {1'b0, rx_hit};

         trans_cnt_slot_ipa #(
            .CNT_WIDTH (CNT_WIDTH)
         ) i_slot (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .inc_i       (inc),
            .dec_i       (dec),
            .last_set_i  (inc & issue_last_i),
            .term_o      (term_sig_o[gi]),
            .full_o      (full_vec[gi]),
            .active_o    (active_vec[gi]),
            .last_seen_o (last_seen),
            .underflow_o (underflow)
         );

         assign err_vec[gi] = underflow
                            | (inc & last_seen)
                            | ((tx_hit | rx_hit) & ~active_vec[gi]);
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_q | (|err_vec);
      end
   end

   assign busy_o = active_vec;
   assign err_o  = err_q;

endmodule

// File: tb/tb_trans_term_tracker_ipa.sv
// Directed bench for trans_term_tracker_ipa with hand-computed expectations.
module tb_trans_term_tracker_ipa;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       issue_req_i;
   logic       issue_gnt_o;
   logic [1:0] issue_sid_i;
   logic       issue_last_i;
   logic       tx_cpl_i;
   logic [1:0] tx_cpl_sid_i;
   logic       rx_cpl_i;
   logic [1:0] rx_cpl_sid_i;
   logic [3:0] term_sig_o;
   logic [3:0] busy_o;
   logic       err_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   trans_term_tracker_ipa dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .issue_req_i  (issue_req_i),
      .issue_gnt_o  (issue_gnt_o),
      .issue_sid_i  (issue_sid_i),
      .issue_last_i (issue_last_i),
      .tx_cpl_i     (tx_cpl_i),
      .tx_cpl_sid_i (tx_cpl_sid_i),
      .rx_cpl_i     (rx_cpl_i),
      .rx_cpl_sid_i (rx_cpl_sid_i),
      .term_sig_o   (term_sig_o),
      .busy_o       (busy_o),
      .err_o        (err_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      issue_req_i  = 1'b0;
      issue_sid_i  = 2'd0;
      issue_last_i = 1'b0;
      tx_cpl_i     = 1'b0;
      tx_cpl_sid_i = 2'd0;
      rx_cpl_i     = 1'b0;
      rx_cpl_sid_i = 2'd0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_ni = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      tick();
      checks++;
      if (term_sig_o !== 4'b0000) begin errors++; $display("FAIL reset_term got %b want 0000", term_sig_o); end
      checks++;
      if (busy_o !== 4'b0000) begin errors++; $display("FAIL reset_busy got %b want 0000", busy_o); end
      checks++;
      if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
      checks++;
      if (issue_gnt_o !== 1'b1) begin errors++; $display("FAIL reset_gnt got %b want 1", issue_gnt_o); end
      $display("test_reset done");
   endtask

   task automatic test_single_burst();
      issue_req_i = 1'b1; issue_sid_i = 2'd1; issue_last_i = 1'b1;
      tick();
      idle_inputs();
      for (int c = 1; c <= 3; c++) begin
         checks++;
         if (busy_o !== 4'b0010 || term_sig_o !== 4'b0000) begin
            errors++; $display("FAIL single_wait c%0d busy %b term %b want 0010/0000", c, busy_o, term_sig_o);
         end
         if (c == 3) begin tx_cpl_i = 1'b1; tx_cpl_sid_i = 2'd1; end
         else tick();
      end
      tick();
      idle_inputs();
      checks++;
      if (term_sig_o !== 4'b0010) begin errors++; $display("FAIL single_term got %b want 0010", term_sig_o); end
      checks++;
      if (busy_o !== 4'b0000) begin errors++; $display("FAIL single_busy_clr got %b want 0000", busy_o); end
      tick();
      checks++;
      if (term_sig_o !== 4'b0000) begin errors++; $display("FAIL single_pulse_len got %b want 0000", term_sig_o); end
      $display("test_single_burst done");
   endtask

   task automatic test_multi_burst();
      // cnt2: 1 -> 1 (issue+cpl) -> 2 (last) -> 1 -> 0 => term
      issue_req_i = 1'b1; issue_sid_i = 2'd2;
      tick();
      rx_cpl_i = 1'b1; rx_cpl_sid_i = 2'd2;
      tick();
      rx_cpl_i = 1'b0; issue_last_i = 1'b1;
      tick();
      idle_inputs();
      checks++;
      if (term_sig_o !== 4'b0000) begin errors++; $display("FAIL multi_after_last got %b want 0000", term_sig_o); end
      rx_cpl_i = 1'b1; rx_cpl_sid_i = 2'd2;
      tick();
      checks++;
      if (term_sig_o !== 4'b0000 || busy_o !== 4'b0100) begin
         errors++; $display("FAIL multi_early term %b busy %b want 0000/0100", term_sig_o, busy_o);
      end
      tick();
      idle_inputs();
      checks++;
      if (term_sig_o !== 4'b0100) begin errors++; $display("FAIL multi_term got %b want 0100", term_sig_o); end
      tick();
      checks++;
      if (term_sig_o !== 4'b0000) begin errors++; $display("FAIL multi_pulse_len got %b want 0000", term_sig_o); end
      $display("test_multi_burst done");
   endtask

   task automatic test_dual_completion();
      issue_req_i = 1'b1; issue_sid_i = 2'd0;
      tick();
      issue_last_i = 1'b1;
      tick();
      idle_inputs();
      tx_cpl_i = 1'b1; tx_cpl_sid_i = 2'd0;
      rx_cpl_i = 1'b1; rx_cpl_sid_i = 2'd0;
      tick();
      idle_inputs();
      checks++;
      if (term_sig_o !== 4'b0001) begin errors++; $display("FAIL dual_term got %b want 0001", term_sig_o); end
      tick();
      checks++;
      if (term_sig_o !== 4'b0000 || err_o !== 1'b0) begin
         errors++; $display("FAIL dual_after term %b err %b want 0000/0", term_sig_o, err_o);
      end
      $display("test_dual_completion done");
   endtask

   task automatic test_backpressure_and_simul_term();
      issue_req_i = 1'b1; issue_sid_i = 2'd3;
      for (int i = 0; i < 15; i++) tick();
      checks++;
      if (issue_gnt_o !== 1'b0) begin errors++; $display("FAIL bp_gnt_sid3 got %b want 0", issue_gnt_o); end
      issue_sid_i = 2'd0;
      #1;
      checks++;
      if (issue_gnt_o !== 1'b1) begin errors++; $display("FAIL bp_gnt_sid0 got %b want 1", issue_gnt_o); end
      idle_inputs();
      tx_cpl_i = 1'b1; tx_cpl_sid_i = 2'd3;
      tick();
      idle_inputs();
      issue_sid_i = 2'd3;
      #1;
      checks++;
      if (issue_gnt_o !== 1'b1) begin errors++; $display("FAIL bp_gnt_return got %b want 1", issue_gnt_o); end
      // sid3: 14 -> 15 with last; then sid0 last issue while sid3 drains
      issue_req_i = 1'b1; issue_last_i = 1'b1;
      tick();
      issue_sid_i = 2'd0;
      rx_cpl_i = 1'b1; rx_cpl_sid_i = 2'd3;
      tick();
      issue_req_i = 1'b0; issue_last_i = 1'b0;
      for (int i = 0; i < 13; i++) tick();
      checks++;
      if (term_sig_o !== 4'b0000 || busy_o !== 4'b1001) begin
         errors++; $display("FAIL simul_pre term %b busy %b want 0000/1001", term_sig_o, busy_o);
      end
      tx_cpl_i = 1'b1; tx_cpl_sid_i = 2'd0;
      tick();
      idle_inputs();
      checks++;
      if (term_sig_o !== 4'b1001) begin errors++; $display("FAIL simul_term got %b want 1001", term_sig_o); end
      tick();
      checks++;
      if (term_sig_o !== 4'b0000 || err_o !== 1'b0) begin
         errors++; $display("FAIL simul_after term %b err %b want 0000/0", term_sig_o, err_o);
      end
      $display("test_backpressure_and_simul_term done");
   endtask

   task automatic test_errors();
      rx_cpl_i = 1'b1; rx_cpl_sid_i = 2'd2;
      tick();
      idle_inputs();
      checks++;
      if (err_o !== 1'b1) begin errors++; $display("FAIL err_idle_cpl got %b want 1", err_o); end
      checks++;
      if (busy_o !== 4'b0000 || term_sig_o !== 4'b0000) begin
         errors++; $display("FAIL err_no_side busy %b term %b want 0000/0000", busy_o, term_sig_o);
      end
      tick();
      tick();
      checks++;
      if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err_o); end
      $display("test_errors done");
   endtask

   task automatic test_reset_mid_op();
      issue_req_i = 1'b1; issue_sid_i = 2'd1;
      tick();
      tick();
      idle_inputs();
      checks++;
      if (busy_o !== 4'b0010) begin errors++; $display("FAIL rst_pre_busy got %b want 0010", busy_o); end
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if (busy_o !== 4'b0000 || term_sig_o !== 4'b0000 || err_o !== 1'b0) begin
         errors++; $display("FAIL rst_async busy %b term %b err %b want 0000/0000/0", busy_o, term_sig_o, err_o);
      end
      tick();
      rst_ni = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (term_sig_o !== 4'b0000 || busy_o !== 4'b0000) begin
            errors++; $display("FAIL rst_post c%0d term %b busy %b want 0000/0000", i, term_sig_o, busy_o);
         end
      end
      $display("test_reset_mid_op done");
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_multi_burst();
      test_dual_completion();
      test_backpressure_and_simul_term();
      test_errors();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
